// File: rtl/song_reader.sv
// Walks a song ROM and hands each {note, duration} entry to note_player, one per done_with_note.
// Define SONG_LOOP_EN to restart at entry 0 instead of stopping in DONE.
module song_reader #(
  parameter int SONG_SEL_WIDTH = 2,
  parameter int INDEX_WIDTH    = 5,
  parameter int NOTE_WIDTH     = 6,
  parameter int DUR_WIDTH      = 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  play,
  input  logic [SONG_SEL_WIDTH-1:0]             song_sel,
  input  logic                                  done_with_note,
  output logic [SONG_SEL_WIDTH+INDEX_WIDTH-1:0] rom_addr,
  input  logic [NOTE_WIDTH+DUR_WIDTH-1:0]       rom_data,
  output logic [NOTE_WIDTH-1:0]                 note_to_load,
  output logic [DUR_WIDTH-1:0]                  duration_to_load,
  output logic                                  load_new_note,
  output logic                                  song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] INDEX_MAX = '1;

  state_t                    state, state_nxt;
  logic [SONG_SEL_WIDTH-1:0] song_reg, song_nxt;
  logic [INDEX_WIDTH-1:0]    index, index_nxt;
  logic [NOTE_WIDTH-1:0]     note_nxt;
  logic [DUR_WIDTH-1:0]      dur_nxt;
  logic                      end_marker;

  assign end_marker = (rom_data == '0);
  assign rom_addr   = {song_reg, index};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      song_reg         <= '0;
      index            <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
    end else begin
      state            <= state_nxt;
      song_reg         <= song_nxt;
      index            <= index_nxt;
      note_to_load     <= note_nxt;
      duration_to_load <= dur_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    song_nxt      = song_reg;
    index_nxt     = index;
    note_nxt      = note_to_load;
    dur_nxt       = duration_to_load;
    load_new_note = 1'b0;
    song_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (play) begin
          song_nxt  = song_sel;
          index_nxt = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (play) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (play) begin
          if (end_marker) begin
`ifdef SONG_LOOP_EN
            index_nxt = '0;
            state_nxt = S_FETCH;
`else
            state_nxt = S_DONE;
`endif
          end else begin
            // A rest (note 0, nonzero duration) is loaded like any other note.
            note_nxt  = rom_data[NOTE_WIDTH+DUR_WIDTH-1:DUR_WIDTH];
            dur_nxt   = rom_data[DUR_WIDTH-1:0];
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        load_new_note = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (done_with_note && play) begin
          if (index == INDEX_MAX) begin
`ifdef SONG_LOOP_EN
            index_nxt = '0;
            state_nxt = S_FETCH;
`else
            state_nxt = S_DONE;
`endif
          end else begin
            index_nxt = index + INDEX_WIDTH'(1);
            state_nxt = S_FETCH;
          end
        end
      end
      S_DONE: begin
        song_done = 1'b1;
        if (!play) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: cycle table for the basic song, plus randomized songs against a list model.
module tb_song_reader;
  localparam int AW = 7;
  localparam int RW = 12;

  logic          clk = 1'b0;
  logic          reset, play, done_with_note;
  logic [1:0]    song_sel;
  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_data;
  logic [5:0]    note_to_load, duration_to_load;
  logic          load_new_note, song_done;

  logic [RW-1:0] rom [128];
  logic [RW-1:0] exp_e [$];
  logic [AW-1:0] exp_a [$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  song_reader dut (
    .clk(clk), .reset(reset), .play(play), .song_sel(song_sel),
    .done_with_note(done_with_note), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .load_new_note(load_new_note), .song_done(song_done)
  );

  typedef struct packed {
    logic       play;
    logic       dwn;
    logic       load;
    logic [5:0] note;
    logic [5:0] dur;
    logic [6:0] addr;
    logic       done;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic p, input logic d, input logic l,
                              input int n, input int du, input int a, input logic dn);
    vec_t v;
    v.play = p; v.dwn = d; v.load = l;
    v.note = n[5:0]; v.dur = du[5:0]; v.addr = a[6:0]; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({load_new_note, note_to_load, duration_to_load, rom_addr, song_done});
  endfunction

  // Expected strobe list: entries in order until an end marker or the last slot.
  function automatic void build_exp(input int s, input int max_n);
    int i = 0;
    logic [RW-1:0] e;
    exp_e.delete();
    exp_a.delete();
    while (exp_e.size() < max_n) begin
      e = rom[s*32+i];
      if (e == '0) begin
`ifdef SONG_LOOP_EN
        if (i == 0) break;
        i = 0;
        continue;
`else
        break;
`endif
      end
      exp_e.push_back(e);
      exp_a.push_back(7'(s*32+i));
      if (i == 31) begin
`ifdef SONG_LOOP_EN
        i = 0;
`else
        break;
`endif
      end else begin
        i++;
      end
    end
  endfunction

  task automatic run_song(input int s, input int max_n);
    int n = 0;
    bit fin = 0;
    int waitc;
    logic [AW-1:0] addr0;
    build_exp(s, max_n);
    song_sel = 2'(s);
    done_with_note = 1'b0;
    while (!fin) begin
      waitc = 0;
      play = 1'b1;
      @(negedge clk);
      while (!load_new_note && !song_done && waitc < 100) begin
        play = ($urandom_range(0, 3) != 0);
        if (n > 0) song_sel = 2'($urandom_range(0, 3));
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 100) begin
        chk("song_timeout", 32'd1, 32'd0);
        fin = 1;
      end else if (song_done) begin
        chk("strobe_count", 32'(n), 32'(exp_e.size()));
        fin = 1;
      end else begin
        if (n < exp_e.size())
          chk("strobe_dat", 32'({rom_addr, note_to_load, duration_to_load}), 32'({exp_a[n], exp_e[n]}));
        else
          chk("extra_strobe", 32'(n), 32'(exp_e.size()));
        n++;
        if (n >= max_n) begin
          fin = 1;
        end else begin
          addr0 = rom_addr;
          repeat ($urandom_range(1, 4)) begin
            play = 1'($urandom_range(0, 1));
            done_with_note = !play && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("wait_hold", 32'({load_new_note, song_done, rom_addr}), 32'({2'b00, addr0}));
          end
          play = 1'b1;
          done_with_note = 1'b1;
          @(negedge clk);
          done_with_note = 1'b0;
        end
      end
    end
    play = 1'b0;
`ifdef SONG_LOOP_EN
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`else
    @(negedge clk);
    chk("idle_after_done", 32'(song_done), 32'd0);
`endif
  endtask

  task automatic wait_load();
    int c = 0;
    while (!load_new_note && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("load_seen", 32'(load_new_note), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nt;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[32] = {6'd1, 6'd2};   rom[33] = {6'd47, 6'd10};
    rom[64] = {6'd0, 6'd5};   rom[65] = {6'd12, 6'd3};
    for (int i = 0; i < 32; i++) rom[96+i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};

    reset = 1'b0; play = 1'b0; done_with_note = 1'b0; song_sel = 2'd1;
    #12;
    chk("reset_outs", outs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    tbl[0]  = mk(1, 0, 0,  0,  0, 32, 0);
    tbl[1]  = mk(1, 0, 0,  0,  0, 32, 0);
    tbl[2]  = mk(1, 0, 1,  1,  2, 32, 0);
    tbl[3]  = mk(1, 0, 0,  1,  2, 32, 0);
    tbl[4]  = mk(1, 1, 0,  1,  2, 33, 0);
    tbl[5]  = mk(1, 0, 0,  1,  2, 33, 0);
    tbl[6]  = mk(1, 0, 1, 47, 10, 33, 0);
    tbl[7]  = mk(1, 0, 0, 47, 10, 33, 0);
    tbl[8]  = mk(0, 1, 0, 47, 10, 33, 0);
    tbl[9]  = mk(1, 0, 0, 47, 10, 33, 0);
    tbl[10] = mk(1, 1, 0, 47, 10, 34, 0);
    tbl[11] = mk(1, 0, 0, 47, 10, 34, 0);
    tbl[12] = mk(1, 0, 0, 47, 10, 34, 1);
    tbl[13] = mk(1, 0, 0, 47, 10, 34, 1);
    tbl[14] = mk(0, 0, 0, 47, 10, 34, 0);
`ifdef SONG_LOOP_EN
    nt = 12;
`else
    nt = 15;
`endif
    for (int i = 0; i < nt; i++) begin
      play = tbl[i].play;
      done_with_note = tbl[i].dwn;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          32'({tbl[i].load, tbl[i].note, tbl[i].dur, tbl[i].addr, tbl[i].done}));
    end
    play = 1'b0; done_with_note = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_song(2, 64);
    run_song(1, 64);
`ifdef SONG_LOOP_EN
    run_song(3, 33);
`else
    run_song(3, 64);
`endif

    for (int k = 0; k < 6; k++) begin
      int mpos;
`ifdef SONG_LOOP_EN
      mpos = $urandom_range(1, 32);
`else
      mpos = (k == 0) ? 0 : $urandom_range(0, 32);
`endif
      for (int i = 0; i < 32; i++)
        rom[i] = (i == mpos) ? 12'd0 : {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
      run_song(0, 40);
    end

    song_sel = 2'd2; play = 1'b1;
    wait_load();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("reset_mid_wait", outs(), 32'd0);
    @(negedge clk);
    reset = 1'b1; song_sel = 2'd3; play = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("restart_no_early_load", 32'(load_new_note), 32'd0);
    @(negedge clk);
    chk("restart_first_load", 32'({load_new_note, rom_addr, rom[96]}),
        32'({1'b1, 7'd96, note_to_load, duration_to_load}));
    #2 reset = 1'b0;
    #1 chk("reset_mid_load", outs(), 32'd0);
    play = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
